// File: rtl/debounce_array.sv
// debounce_array: multi-channel push-button / switch conditioner.
// Each channel goes through optional polarity inversion, a two-flop
// synchroniser and a saturating stability counter. The block outputs a
// debounced level plus one-cycle press and release strobes.
// Optional feature: define DEBOUNCE_ARRAY_AUTOREPEAT_EN to add per-channel
// auto-repeat press strobes while a button is held.
module debounce_array #(
    parameter int CHANNELS      = 4,
    parameter int CNT_DEPTH     = 10485760,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] raw_sig,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse
);

    localparam int CNT_W = (CNT_DEPTH > 1) ? $clog2(CNT_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_DEPTH - 1);

    // Parameter sanity: refuse to elaborate with out-of-range settings.
    if (CHANNELS < 1 || CNT_DEPTH < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_param
        $error("debounce_array: parameter out of range");
    end

    // Pin levels normalised so that 1 always means pressed.
    logic [CHANNELS-1:0] pin_norm;
    assign pin_norm = raw_sig ^ {CHANNELS{ACTIVE_LOW}};

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] accept;

`ifdef DEBOUNCE_ARRAY_AUTOREPEAT_EN
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam logic [RC_W-1:0] RC_DELAY  = RC_W'(REPEAT_DELAY);
    localparam logic [RC_W-1:0] RC_PERIOD = RC_W'(REPEAT_PERIOD);

    // rc counts cycles since the last press strobe; phase_q marks that the
    // first (long) repeat delay has elapsed and the short period applies.
    logic [RC_W-1:0]     rc_q [CHANNELS];
    logic [RC_W-1:0]     rc_d [CHANNELS];
    logic [CHANNELS-1:0] phase_q, phase_d;
`endif

    // Two-flop synchroniser on the normalised pin levels.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, giving a true shift chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_norm;
            sync2_q <= sync1_q;
        end
    end

    // Stability counter, level acceptance and strobe generation per channel.
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        accept    = '0;
        cnt_d     = cnt_q;
`ifdef DEBOUNCE_ARRAY_AUTOREPEAT_EN
        rc_d      = rc_q;
        phase_d   = phase_q;
`endif
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (sync2_q[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                accept[ch]    = 1'b1;
                level_d[ch]   = sync2_q[ch];
                cnt_d[ch]     = '0;
                press_d[ch]   = sync2_q[ch];
                release_d[ch] = ~sync2_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end

`ifdef DEBOUNCE_ARRAY_AUTOREPEAT_EN
            // An accepted edge (press or release) restarts the repeat
            // schedule; release therefore beats a repeat due this cycle.
            if (accept[ch]) begin
                rc_d[ch]    = '0;
                phase_d[ch] = 1'b0;
            end else if (level_q[ch]) begin
                if ((rc_q[ch] + RC_W'(1)) == (phase_q[ch] ? RC_PERIOD : RC_DELAY)) begin
                    press_d[ch] = 1'b1;
                    rc_d[ch]    = '0;
                    phase_d[ch] = 1'b1;
                end else begin
                    rc_d[ch] = rc_q[ch] + RC_W'(1);
                end
            end else begin
                rc_d[ch]    = '0;
                phase_d[ch] = 1'b0;
            end
`endif
        end
    end

    // Level, strobe and counter registers.
    // NOTE: the per-channel counter arrays are plain flops, not RAM, so they
    // are cleared by reset like any other state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef DEBOUNCE_ARRAY_AUTOREPEAT_EN
    // Auto-repeat counters and phase flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                rc_q[ch] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            rc_q    <= rc_d;
        end
    end
`endif

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: directed table-driven bench for debounce_array with
// CNT_DEPTH = 4 (level update on the 6th edge counting the sampling edge).
// A second instance exercises ACTIVE_LOW = 1. The auto-repeat sequence is
// compiled only when DEBOUNCE_ARRAY_AUTOREPEAT_EN is defined.
module tb_debounce_array;

    localparam int CH = 4;

    logic          clk;
    logic          resetn;
    logic [CH-1:0] raw_sig, raw_al;
    logic [CH-1:0] level, press_pulse, release_pulse;
    logic [CH-1:0] level_al, press_al, release_al;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [CH-1:0] raw;
        logic [CH-1:0] lvl;
        logic [CH-1:0] prs;
        logic [CH-1:0] rel;
    } vec_t;

    vec_t tbl[$];

    debounce_array #(
        .CHANNELS(CH), .CNT_DEPTH(4), .ACTIVE_LOW(1'b0),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .resetn(resetn), .raw_sig(raw_sig),
        .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse)
    );

    debounce_array #(
        .CHANNELS(CH), .CNT_DEPTH(4), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut_al (
        .clk(clk), .resetn(resetn), .raw_sig(raw_al),
        .level(level_al), .press_pulse(press_al), .release_pulse(release_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [CH-1:0] raw, input logic [CH-1:0] lvl,
                                input logic [CH-1:0] prs, input logic [CH-1:0] rel,
                                input int n);
        vec_t v;
        v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin
        // Vector k: raw applied before edge k, outputs expected after edge k.
        // Reset release with all pins pressed: accepted on edge 6, then drop.
        add(4'hF, 4'h0, 4'h0, 4'h0, 5);
        add(4'hF, 4'hF, 4'hF, 4'h0, 1);
        add(4'h0, 4'hF, 4'h0, 4'h0, 5);
        add(4'h0, 4'h0, 4'h0, 4'hF, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        // 3-cycle glitch on ch0: rejected.
        add(4'h1, 4'h0, 4'h0, 4'h0, 3);
        add(4'h0, 4'h0, 4'h0, 4'h0, 6);
        // 4-cycle pulse on ch0: exactly CNT_DEPTH, accepted then released.
        add(4'h1, 4'h0, 4'h0, 4'h0, 4);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(4'h0, 4'h1, 4'h1, 4'h0, 1);
        add(4'h0, 4'h1, 4'h0, 4'h0, 3);
        add(4'h0, 4'h0, 4'h0, 4'h1, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        // ch1 press/release latency.
        add(4'h2, 4'h0, 4'h0, 4'h0, 5);
        add(4'h2, 4'h2, 4'h2, 4'h0, 1);
        add(4'h0, 4'h2, 4'h0, 4'h0, 5);
        add(4'h0, 4'h0, 4'h0, 4'h2, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        // ch0 and ch3 together, ch0 bounces once; joint release.
        add(4'h9, 4'h0, 4'h0, 4'h0, 1);
        add(4'h8, 4'h0, 4'h0, 4'h0, 1);
        add(4'h9, 4'h0, 4'h0, 4'h0, 3);
        add(4'h9, 4'h8, 4'h8, 4'h0, 1);
        add(4'h9, 4'h8, 4'h0, 4'h0, 1);
        add(4'h9, 4'h9, 4'h1, 4'h0, 1);
        add(4'h0, 4'h9, 4'h0, 4'h0, 5);
        add(4'h0, 4'h0, 4'h0, 4'h9, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);

        // Reset held with pins pressed: everything stays clear.
        resetn  = 1'b0;
        raw_sig = 4'hF;
        raw_al  = 4'hF;
        repeat (3) tick();
        check("reset level", level, 4'h0);
        check("reset press", press_pulse, 4'h0);
        check("reset release", release_pulse, 4'h0);
        check("reset al level", level_al, 4'h0);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            raw_sig = tbl[i].raw;
            tick();
            check($sformatf("v%0d level", i + 1), level, tbl[i].lvl);
            check($sformatf("v%0d press", i + 1), press_pulse, tbl[i].prs);
            check($sformatf("v%0d release", i + 1), release_pulse, tbl[i].rel);
        end

        // Active-low instance: idle-high pins never look pressed.
        check("al idle level", level_al, 4'h0);
        check("al idle press", press_al, 4'h0);
        raw_al = 4'hB;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("al press e%0d level", k), level_al, (k >= 6) ? 4'h4 : 4'h0);
            check($sformatf("al press e%0d press", k), press_al, (k == 6) ? 4'h4 : 4'h0);
        end
        raw_al = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("al rel e%0d level", k), level_al, (k >= 6) ? 4'h0 : 4'h4);
            check($sformatf("al rel e%0d release", k), release_al, (k == 6) ? 4'h4 : 4'h0);
        end

        // Asynchronous reset in the middle of a count.
        raw_sig = 4'h4;
        repeat (4) tick();
        #2 resetn = 1'b0;
        #1;
        check("midreset sync clear", level | press_pulse | release_pulse, 4'h0);
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("rearm e%0d level", k), level, (k >= 6) ? 4'h4 : 4'h0);
            check($sformatf("rearm e%0d press", k), press_pulse, (k == 6) ? 4'h4 : 4'h0);
        end
        raw_sig = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("unarm e%0d release", k), release_pulse, (k == 6) ? 4'h4 : 4'h0);
        end

`ifdef DEBOUNCE_ARRAY_AUTOREPEAT_EN
        // Hold ch0: presses at T, T+8, T+11, T+14, T+17; pin dropped so the
        // release lands at T+20, where a repeat would also be due.
        raw_sig = 4'h1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("rpt pre e%0d press", k), press_pulse, 4'h0);
        end
        for (int k = 0; k <= 26; k++) begin
            logic exp_p;
            tick();
            exp_p = (k == 0) || (k >= 8 && k <= 19 && ((k - 8) % 3) == 0);
            check($sformatf("rpt T+%0d level", k), level, (k <= 19) ? 4'h1 : 4'h0);
            check($sformatf("rpt T+%0d press", k), press_pulse, {3'b000, exp_p});
            check($sformatf("rpt T+%0d release", k), release_pulse, (k == 20) ? 4'h1 : 4'h0);
            if (k == 14) raw_sig = 4'h0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/debounce_array.md
# debounce_array

Multi-channel input conditioner for the board's push-buttons and switches. Each channel passes through a two-flop synchroniser, an optional polarity inversion and a saturating stability counter. The block produces a clean debounced level plus single-cycle press and release strobes per channel. It sits between the raw FPGA pins and the game control logic (flap/start/pause), replacing per-button debouncer instances with one parametrised array.

## Interface
- CHANNELS, 4, number of independent input channels (>= 1)
- CNT_DEPTH, 10485760, cycles of continuous disagreement required to accept a new level (>= 2)
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; inverted before synchronisation
- REPEAT_DELAY, 50000000, cycles from press strobe to first auto-repeat strobe (>= 1; used only with auto-repeat)
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes (>= 1; used only with auto-repeat)

Ports:
- clk  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- raw_sig  in  CHANNELS  unsynchronised pin levels
- level  out  CHANNELS  debounced logical level (1 = pressed)
- press_pulse  out  CHANNELS  one-cycle strobe on accepted 0->1 (and on auto-repeat)
- release_pulse  out  CHANNELS  one-cycle strobe on accepted 1->0

## Operation
- Per-channel pipeline: n = raw_sig ^ {CHANNELS{ACTIVE_LOW}} -> sync1 -> sync2 (two flops, reset 0).
- Stability counter cnt, width $clog2(CNT_DEPTH), reset 0:
  - sync2 == level: cnt <= 0.
  - sync2 != level and cnt != CNT_DEPTH-1: cnt <= cnt+1.
  - sync2 != level and cnt == CNT_DEPTH-1: level <= sync2, cnt <= 0, strobe fires.
- Any single agreeing cycle restarts the count; glitches shorter than CNT_DEPTH cycles never reach level.
- Strobes are registered. They assert on the same edge that updates level and deassert on the next edge. press_pulse fires when the new level is 1; release_pulse fires when the new level is 0.
- Channels are fully independent; any combination may strobe in the same cycle.
- Reset mid-count: all counters, sync flops, level and strobes clear immediately (async). A pin held pressed through reset is re-accepted CNT_DEPTH+2 cycles after deassertion.

## Timing
- Reset values: level = 0, press_pulse = 0, release_pulse = 0.
- Latency from a stable raw edge (sampled at edge E0) to the level/strobe update: 2 + CNT_DEPTH clock edges.
- Strobe width is exactly 1 cycle. A channel never asserts press_pulse and release_pulse together.
- resetn is applied asynchronously. Release is expected synchronous to clk; no internal reset synchroniser is provided.

## Configuration
- Macro DEBOUNCE_ARRAY_AUTOREPEAT_EN.
- Defined: each channel has a repeat counter rc, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - rc clears on the press strobe and counts while level == 1.
  - Extra press_pulse strobes fire at T+REPEAT_DELAY and then every REPEAT_PERIOD cycles, where T is the press strobe cycle.
  - rc clears, and repeats stop, when level goes to 0.
  - A release accepted in the same cycle a repeat is due wins: release_pulse = 1, press_pulse = 0.
- Undefined: no repeat logic is synthesised; press_pulse fires only on accepted 0->1 transitions. Ports are identical in both builds.

## Test plan
- Reset: hold resetn = 0 with raw_sig = 4'hF, ACTIVE_LOW = 0, CNT_DEPTH = 4 -> all outputs 0. Release resetn -> level[3:0] = F and press_pulse = F for one cycle, 6 cycles after release.
- Glitch reject: CNT_DEPTH = 4, pulse raw_sig[0] high for 3 cycles -> level, press_pulse and release_pulse stay 0.
- Acceptance/latency: raw_sig[1] high held -> level[1] = 1 and press_pulse[1] = 1 exactly 6 edges later. Drop it -> release_pulse[1] after 6 edges.
- Polarity: ACTIVE_LOW = 1, raw_sig = 4'hF idle -> level stays 0. Drive raw_sig[2] = 0 -> press_pulse[2] after CNT_DEPTH+2.
- Independence: toggle channels 0 and 3 on the same cycle with different bounce patterns -> each strobes once at its own stable point. Strobes on both channels in the same cycle are allowed.
- Auto-repeat (macro on, REPEAT_DELAY = 8, REPEAT_PERIOD = 3): hold channel 0 -> press strobes at T, T+8, T+11, T+14. Release -> release_pulse once and no further press strobes.
